// File: rtl/picnic_pkg.sv
// Shared definitions for the signing datapath: hash-arbiter FSM encoding,
// default digest width and hash domain-separation prefixes.
package picnic_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_WAIT    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    localparam int HASH_DIG_W = 256;

    localparam logic [7:0] HASH_PREFIX_CH = 8'h01;
    localparam logic [7:0] HASH_PREFIX_CV = 8'h02;

endpackage

// File: rtl/hash_core_arbiter_rr_pick.sv
// Combinational N-way round-robin priority encoder: returns the first set
// request found searching upward from i_ptr, wrapping modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Walk the ring from farthest to nearest so the nearest hit to i_ptr wins.
    always_comb begin
        logic [IDX_W-1:0] w_j;
        // NOTE: every output gets a default before the search; a path that skips
        // an assignment would otherwise infer a latch.
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_j      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = IDX_W'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) begin
                o_any = 1'b1;
                o_idx = w_j;
            end
        end
        if (o_any) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/hash_core_arbiter.sv
// Shares one SHAKE/SHA3 core between N requesters with round-robin arbitration,
// one job in flight, a latency watchdog and a held copy of the last digest.
module hash_core_arbiter
    import picnic_pkg::*;
#(
    parameter int N       = 4,
    parameter int DIG_W   = HASH_DIG_W,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [8*N-1:0]     req_prefix,
    input  logic [LEN_W*N-1:0] req_len,
    output logic [N-1:0]       grant,
    output logic [N-1:0]       ack,
    output logic [DIG_W-1:0]   digest,
    output logic               err,
    output logic               core_start,
    output logic [7:0]         core_prefix,
    output logic [LEN_W-1:0]   core_len,
    input  logic               core_done,
    input  logic [DIG_W-1:0]   core_digest
);

    localparam int IDX_W = $clog2(N);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    arb_state_t         r_state,       w_state_nxt;
    logic [N-1:0]       r_grant,       w_grant_nxt;
    logic [IDX_W-1:0]   r_owner,       w_owner_nxt;
    logic [N-1:0]       r_ack,         w_ack_nxt;
    logic [DIG_W-1:0]   r_digest,      w_digest_nxt;
    logic               r_err,         w_err_nxt;
    logic               r_core_start,  w_core_start_nxt;
    logic [7:0]         r_core_prefix, w_core_prefix_nxt;
    logic [LEN_W-1:0]   r_core_len,    w_core_len_nxt;
    logic [IDX_W-1:0]   r_rr_ptr,      w_rr_ptr_nxt;
    logic               r_abandon,     w_abandon_nxt;
    logic [WD_W-1:0]    r_wd,          w_wd_nxt;

    logic [N-1:0]       w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_abandon_now;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // The owner has walked away if it already dropped req or drops it now.
    assign w_abandon_now = r_abandon | ~|(req & r_grant);

    // Next-state and next-output logic; every output below is registered.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_owner_nxt       = r_owner;
        w_ack_nxt         = '0;
        w_digest_nxt      = r_digest;
        w_err_nxt         = r_err;
        w_core_start_nxt  = 1'b0;
        w_core_prefix_nxt = r_core_prefix;
        w_core_len_nxt    = r_core_len;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_abandon_nxt     = r_abandon;
        w_wd_nxt          = r_wd;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_grant_nxt       = w_pick_onehot;
                    w_owner_nxt       = w_pick_idx;
                    w_core_prefix_nxt = req_prefix[int'(w_pick_idx)*8 +: 8];
                    w_core_len_nxt    = req_len[int'(w_pick_idx)*LEN_W +: LEN_W];
                    w_state_nxt       = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                w_core_start_nxt = 1'b1;
                w_wd_nxt         = '0;
                w_abandon_nxt    = w_abandon_now;
                w_state_nxt      = ARB_WAIT;
            end
            ARB_WAIT: begin
                w_abandon_nxt = w_abandon_now;
                if (core_done) begin
                    // Completion beats a watchdog expiry in the same cycle.
                    w_digest_nxt = core_digest;
                    w_ack_nxt    = w_abandon_now ? '0 : r_grant;
                    w_state_nxt  = ARB_RELEASE;
                end else if (r_wd == WD_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ARB_RELEASE;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            ARB_RELEASE: begin
                w_rr_ptr_nxt  = (r_owner == IDX_LAST) ? '0 : r_owner + 1'b1;
                w_grant_nxt   = '0;
                w_abandon_nxt = 1'b0;
                w_state_nxt   = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // State and output registers; reset abandons any job in flight without ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ARB_IDLE;
            r_grant       <= '0;
            r_owner       <= '0;
            r_ack         <= '0;
            r_digest      <= '0;
            r_err         <= 1'b0;
            r_core_start  <= 1'b0;
            r_core_prefix <= '0;
            r_core_len    <= '0;
            r_rr_ptr      <= '0;
            r_abandon     <= 1'b0;
            r_wd          <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_owner       <= w_owner_nxt;
            r_ack         <= w_ack_nxt;
            r_digest      <= w_digest_nxt;
            r_err         <= w_err_nxt;
            r_core_start  <= w_core_start_nxt;
            r_core_prefix <= w_core_prefix_nxt;
            r_core_len    <= w_core_len_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_abandon     <= w_abandon_nxt;
            r_wd          <= w_wd_nxt;
        end
    end

    assign grant       = r_grant;
    assign ack         = r_ack;
    assign digest      = r_digest;
    assign err         = r_err;
    assign core_start  = r_core_start;
    assign core_prefix = r_core_prefix;
    assign core_len    = r_core_len;

endmodule
